// File: rtl/qdr_ui_pkg.sv
// Shared constants for the QDRII+ user-interface responder: FSM encoding,
// byte-lane width and legal parameter ranges.
package qdr_ui_pkg;

    localparam int unsigned LANE_W     = 9;
    localparam int unsigned RD_LAT_MIN = 2;
    localparam int unsigned RD_LAT_MAX = 32;
    localparam int unsigned CAL_MIN    = 1;
    localparam int unsigned CAL_MAX    = 65535;
    localparam int unsigned CAL_CNT_W  = 16;

    localparam logic [0:0] ST_CAL = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    function automatic logic rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic logic cal_cycles_legal(input int unsigned cyc);
        return (cyc >= CAL_MIN) && (cyc <= CAL_MAX);
    endfunction

endpackage

// File: rtl/qdr_ui_rdpipe.sv
// Read-return delay line: DEPTH-stage valid/data shift register with a
// synchronous flush; the output data register holds its value between valids.
module qdr_ui_rdpipe #(
    parameter int unsigned DATA_W = 144,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DEPTH-1:0]  r_vld;
    logic [DATA_W-1:0] r_dat [DEPTH-1];
    logic [DATA_W-1:0] r_dat_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[DEPTH-2:0], i_valid};
        end
    end

    // Inner stages only move when carrying a valid entry; no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            r_dat[0] <= i_data;
        end
        for (int k = 1; k < int'(DEPTH) - 1; k++) begin
            if (r_vld[k-1]) begin
                r_dat[k] <= r_dat[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dat_out <= '0;
        end else if (r_vld[DEPTH-2]) begin
            r_dat_out <= r_dat[DEPTH-2];
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_data  = r_dat_out;

endmodule

// File: rtl/qdr_ui_responder.sv
// BRAM-backed stand-in for the QDRII+ controller user interface.
// Optional QDR_UI_RESPONDER_STATS_EN adds accepted write/read counters.
module qdr_ui_responder
    import qdr_ui_pkg::*;
#(
    parameter int unsigned APP_DATA_WIDTH = 144,
    parameter int unsigned APP_BW_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH     = 18,
    parameter int unsigned MEM_ADDR_BITS  = 10,
    parameter int unsigned RD_LAT         = 8,
    parameter int unsigned CAL_CYCLES     = 256
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      app_wr_cmd,
    input  logic [ADDR_WIDTH-1:0]     app_wr_addr,
    input  logic [APP_DATA_WIDTH-1:0] app_wr_data,
    input  logic [APP_BW_WIDTH-1:0]   app_wr_bw_n,
    input  logic                      app_rd_cmd,
    input  logic [ADDR_WIDTH-1:0]     app_rd_addr,
    output logic                      app_rd_valid,
    output logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      cal_done,
    output logic                      cmd_err
`ifdef QDR_UI_RESPONDER_STATS_EN
    ,
    output logic [31:0]               wr_count,
    output logic [31:0]               rd_count
`endif
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_BITS;

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("qdr_ui_responder: RD_LAT out of range");
    end
    if (!cal_cycles_legal(CAL_CYCLES)) begin : g_bad_cal
        $error("qdr_ui_responder: CAL_CYCLES out of range");
    end
    if (APP_BW_WIDTH * LANE_W != APP_DATA_WIDTH) begin : g_bad_bw
        $error("qdr_ui_responder: APP_BW_WIDTH does not match APP_DATA_WIDTH");
    end

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [CAL_CNT_W-1:0] r_cal_cnt;
    logic [CAL_CNT_W-1:0] w_cal_cnt_nxt;
    logic                 r_cal_done;
    logic                 r_cmd_err;

    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic [MEM_ADDR_BITS-1:0]  w_wr_idx;
    logic [MEM_ADDR_BITS-1:0]  w_rd_idx;
    logic                      w_unused_addr;

    logic [APP_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [APP_DATA_WIDTH-1:0] r_rd_q;
    logic                      r_rd_q_vld;

    // Calibration FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_CAL;
            r_cal_cnt  <= '0;
            r_cal_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cal_cnt  <= w_cal_cnt_nxt;
            r_cal_done <= (w_state_nxt == ST_RUN);
        end
    end

    // Calibration FSM next state: count out CAL_CYCLES, then run until reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_cal_cnt_nxt = r_cal_cnt;
        case (r_state)
            ST_CAL: begin
                if (r_cal_cnt == CAL_CNT_W'(CAL_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cal_cnt_nxt = r_cal_cnt + CAL_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_wr_acc      = app_wr_cmd & r_cal_done;
    assign w_rd_acc      = app_rd_cmd & r_cal_done;
    assign w_wr_idx      = app_wr_addr[MEM_ADDR_BITS-1:0];
    assign w_rd_idx      = app_rd_addr[MEM_ADDR_BITS-1:0];
    assign w_unused_addr = ^{app_wr_addr[ADDR_WIDTH-1:MEM_ADDR_BITS],
                             app_rd_addr[ADDR_WIDTH-1:MEM_ADDR_BITS]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cmd_err <= 1'b0;
        end else if ((app_wr_cmd | app_rd_cmd) & ~r_cal_done) begin
            r_cmd_err <= 1'b1;
        end
    end

    // Storage is deliberately not reset; each 9-bit lane has its own enable.
    always_ff @(posedge sys_clk) begin
        for (int l = 0; l < int'(APP_BW_WIDTH); l++) begin
            if (w_wr_acc && !app_wr_bw_n[l]) begin
                r_mem[w_wr_idx][l*LANE_W +: LANE_W] <= app_wr_data[l*LANE_W +: LANE_W];
            end
        end
    end

    // Registered read sees pre-write contents on a same-address collision.
    always_ff @(posedge sys_clk) begin
        if (w_rd_acc) begin
            r_rd_q <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd_q_vld <= 1'b0;
        end else begin
            r_rd_q_vld <= w_rd_acc;
        end
    end

    qdr_ui_rdpipe #(
        .DATA_W (APP_DATA_WIDTH),
        .DEPTH  (RD_LAT)
    ) u_rdpipe (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_valid (r_rd_q_vld),
        .i_data  (r_rd_q),
        .o_valid (app_rd_valid),
        .o_data  (app_rd_data)
    );

    assign cal_done = r_cal_done;
    assign cmd_err  = r_cmd_err;

`ifdef QDR_UI_RESPONDER_STATS_EN
    logic [31:0] r_wr_count;
    logic [31:0] r_rd_count;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            if (w_wr_acc) r_wr_count <= r_wr_count + 32'd1;
            if (w_rd_acc) r_rd_count <= r_rd_count + 32'd1;
        end
    end

    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;
`endif

endmodule
